// File: rtl/sine_meter.sv
// Sine waveform meter: rising midscale crossings with hysteresis, per-cycle period/peak/trough/amplitude.
// Optional SINE_METER_AVG_EN: report a 4-measurement average period and only every 4th result.
module sine_meter #(
    parameter int unsigned MID   = 128,
    parameter int unsigned HYST  = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [7:0]       sample,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       peak,
    output logic [7:0]       trough,
    output logic [7:0]       amplitude,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [7:0]       RISE    = 8'(MID + HYST);
    localparam logic [7:0]       FALL    = 8'(MID - HYST);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, LOW_FIRST, HIGH, LOW} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       run_max, run_max_nxt;
    logic [7:0]       run_min, run_min_nxt;
    logic             rise_c, fall_c, sat_c, meas_c;

    assign rise_c = (sample >= RISE);
    assign fall_c = (sample <= FALL);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; saturation overrides a coincident crossing
    always_comb begin
        state_nxt = state;
        if (sample_valid) begin
            case (state)
                IDLE:      if (fall_c) state_nxt = LOW_FIRST;
                LOW_FIRST: if (rise_c) state_nxt = HIGH;
                HIGH: begin
                    if (sat_c)       state_nxt = IDLE;
                    else if (fall_c) state_nxt = LOW;
                end
                LOW: begin
                    if (sat_c)       state_nxt = IDLE;
                    else if (rise_c) state_nxt = HIGH;
                end
                default:             state_nxt = IDLE;
            endcase
        end
    end

    // Event decode and next values of the running measurement
    always_comb begin
        sat_c       = sample_valid && (state == HIGH || state == LOW) && (cnt == CNT_MAX);
        meas_c      = sample_valid && (state == LOW) && rise_c && !sat_c;
        cnt_nxt     = cnt;
        run_max_nxt = run_max;
        run_min_nxt = run_min;
        if (sat_c) begin
            cnt_nxt     = '0;
            run_max_nxt = 8'd0;
            run_min_nxt = 8'd255;
        end else if (meas_c || (sample_valid && state == LOW_FIRST && rise_c)) begin
            cnt_nxt     = CNT_W'(1);
            run_max_nxt = sample;
            run_min_nxt = sample;
        end else if (sample_valid && (state == HIGH || state == LOW)) begin
            cnt_nxt     = cnt + CNT_W'(1);
            run_max_nxt = (sample > run_max) ? sample : run_max;
            run_min_nxt = (sample < run_min) ? sample : run_min;
        end
    end

`ifdef SINE_METER_AVG_EN
    localparam int unsigned SUM_W = CNT_W + 2;
    logic [SUM_W-1:0] sum;
    logic [1:0]       grp;
    logic [SUM_W-1:0] sum_tot;

    assign sum_tot = sum + SUM_W'(cnt);
`endif

    // Measurement and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            run_max      <= 8'd0;
            run_min      <= 8'd255;
            period       <= '0;
            peak         <= 8'd0;
            trough       <= 8'd0;
            amplitude    <= 8'd0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
`ifdef SINE_METER_AVG_EN
            sum          <= '0;
            grp          <= 2'd0;
`endif
        end else begin
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            cnt          <= cnt_nxt;
            run_max      <= run_max_nxt;
            run_min      <= run_min_nxt;
            if (sat_c) begin
                timeout <= 1'b1;
                locked  <= 1'b0;
`ifdef SINE_METER_AVG_EN
                sum     <= '0;
                grp     <= 2'd0;
`endif
            end else if (meas_c) begin
`ifdef SINE_METER_AVG_EN
                if (grp == 2'd3) begin
                    period       <= CNT_W'(sum_tot >> 2);
                    peak         <= run_max;
                    trough       <= run_min;
                    amplitude    <= run_max - run_min;
                    period_valid <= 1'b1;
                    locked       <= 1'b1;
                    sum          <= '0;
                    grp          <= 2'd0;
                end else begin
                    sum <= sum_tot;
                    grp <= grp + 2'd1;
                end
`else
                period       <= cnt;
                peak         <= run_max;
                trough       <= run_min;
                amplitude    <= run_max - run_min;
                period_valid <= 1'b1;
                locked       <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sine_meter.sv
// Directed self-checking bench for sine_meter; a second CNT_W=8 instance covers counter saturation.
module tb_sine_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample = 8'd0;

    logic [15:0] period;
    logic [7:0]  peak, trough, amplitude;
    logic        period_valid, locked, timeout;

    logic [7:0]  period8, peak8, trough8, amplitude8;
    logic        period_valid8, locked8, timeout8;

    int errors = 0;
    int checks = 0;
    int pv_cnt = 0;
    int to8_cnt = 0;

    always #5 clk = ~clk;

    sine_meter dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .period(period), .peak(peak), .trough(trough), .amplitude(amplitude),
        .period_valid(period_valid), .locked(locked), .timeout(timeout)
    );

    sine_meter #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .period(period8), .peak(peak8), .trough(trough8), .amplitude(amplitude8),
        .period_valid(period_valid8), .locked(locked8), .timeout(timeout8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sine(input int ph);
        real r;
        r = 127.5 + 127.5 * $sin(6.283185307179586 * real'(ph & 255) / 256.0);
        return 8'(int'(r));
    endfunction

    // One clock: drive on the falling edge, observe just after the rising edge
    task automatic drive(input logic [7:0] s, input logic v);
        @(negedge clk);
        sample       = s;
        sample_valid = v;
        @(posedge clk);
        #1;
        if (period_valid) pv_cnt++;
        if (timeout8)     to8_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic square(input int n, input int cycles);
        for (int c = 0; c < cycles; c++)
            for (int k = 0; k < n; k++)
                drive((k < n / 2) ? 8'd150 : 8'd100, 1'b1);
    endtask

    initial begin
        int to_idx;

        do_reset();
        check("rst_period", 32'(period), 0);
        check("rst_peak", 32'(peak), 0);
        check("rst_trough", 32'(trough), 0);
        check("rst_amp", 32'(amplitude), 0);
        check("rst_pv", 32'(period_valid), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_timeout", 32'(timeout), 0);

`ifndef SINE_METER_AVG_EN
        // Step-1 sine: exactly one result within the first 600 samples
        pv_cnt = 0;
        for (int i = 0; i < 600; i++) drive(sine(i), 1'b1);
        check("s1_pulses", 32'(pv_cnt), 1);
        check("s1_period", 32'(period), 256);
        check("s1_peak", 32'(peak), 255);
        check("s1_trough", 32'(trough), 0);
        check("s1_amp", 32'(amplitude), 255);
        check("s1_locked", 32'(locked), 1);

        // Step-4 sine interleaved with inverted junk on invalid cycles
        for (int i = 0; i < 320; i++) begin
            drive(sine(88 + 4 * i), 1'b1);
            drive(8'd255 - sine(88 + 4 * i), 1'b0);
        end
        check("s4_period", 32'(period), 64);
        check("s4_peak", 32'(peak), 255);
        check("s4_trough", 32'(trough), 0);

        // Square wave, then band samples that must not disturb it
        square(6, 4);
        pv_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            drive(8'd150, 1'b1); drive(8'd140, 1'b1); drive(8'd150, 1'b1);
            drive(8'd100, 1'b1); drive(8'd120, 1'b1); drive(8'd100, 1'b1);
        end
        check("sq_pulses", 32'(pv_cnt), 5);
        check("sq_period", 32'(period), 6);
        check("sq_peak", 32'(peak), 150);
        check("sq_trough", 32'(trough), 100);
        check("sq_amp", 32'(amplitude), 50);

        // Minimum reportable period
        square(2, 4);
        check("p2_period", 32'(period), 2);
        check("p2_amp", 32'(amplitude), 50);

        // Constant 200 on the 8-bit instance: saturation on the 256th sample
        to_idx = -1;
        to8_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            drive(8'd200, 1'b1);
            if (timeout8 && to_idx < 0) to_idx = i;
        end
        check("to_index", 32'(to_idx), 255);
        check("to_count", 32'(to8_cnt), 1);
        check("to_locked8", 32'(locked8), 0);
        check("to_period8", 32'(period8), 2);
        check("to_wide_locked", 32'(locked), 1);
        check("to_wide_timeout", 32'(timeout), 0);

        // Resumed sine relocks the 8-bit instance
        to8_cnt = 0;
        for (int i = 0; i < 260; i++) drive(sine(4 * i), 1'b1);
        check("rl_locked8", 32'(locked8), 1);
        check("rl_period8", 32'(period8), 64);
        check("rl_peak8", 32'(peak8), 255);
        check("rl_timeouts", 32'(to8_cnt), 0);

        // Reset while in HIGH discards the partial cycle
        square(6, 2);
        drive(8'd150, 1'b1);
        drive(8'd150, 1'b1);
        do_reset();
        check("mr_period", 32'(period), 0);
        check("mr_peak", 32'(peak), 0);
        check("mr_locked", 32'(locked), 0);
        check("mr_pv", 32'(period_valid), 0);
        pv_cnt = 0;
        drive(8'd150, 1'b1); drive(8'd150, 1'b1);
        for (int k = 0; k < 3; k++) drive(8'd100, 1'b1);
        for (int k = 0; k < 3; k++) drive(8'd150, 1'b1);
        for (int k = 0; k < 3; k++) drive(8'd100, 1'b1);
        check("mr_no_early", 32'(pv_cnt), 0);
        drive(8'd150, 1'b1);
        check("mr_pulse", 32'(pv_cnt), 1);
        check("mr_period2", 32'(period), 6);
        check("mr_locked2", 32'(locked), 1);
        do_reset();
`endif

        // Periods 64, 64, 65, 66
        pv_cnt = 0;
        drive(8'd100, 1'b1);
        square(64, 2);
        square(65, 1);
        square(66, 1);
`ifdef SINE_METER_AVG_EN
        check("grp_no_early", 32'(pv_cnt), 0);
        check("grp_unlocked", 32'(locked), 0);
`else
        check("grp_early", 32'(pv_cnt), 3);
`endif
        drive(8'd150, 1'b1);
`ifdef SINE_METER_AVG_EN
        check("grp_pulses", 32'(pv_cnt), 1);
        check("grp_period", 32'(period), 64);
`else
        check("grp_pulses", 32'(pv_cnt), 4);
        check("grp_period", 32'(period), 66);
`endif
        check("grp_peak", 32'(peak), 150);
        check("grp_trough", 32'(trough), 100);
        check("grp_amp", 32'(amplitude), 50);
        check("grp_locked", 32'(locked), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sine_meter.md
Name: sine_meter

Overview:
- Receive-side counterpart of the sine LUT generator: consumes a stream of 8-bit offset-binary sine samples (midscale 128) and measures the waveform.
- Detects rising midscale crossings with hysteresis; reports period in samples, peak, trough and peak-to-peak amplitude once per cycle.
- Sits after the generator output (loopback self-test) or after an external ADC path; results go to status registers / uo_out muxing.

Parameters:
- MID, 128, midscale threshold centre.
- HYST, 16, hysteresis half-width; rise threshold = MID+HYST, fall threshold = MID-HYST.
- CNT_W, 16, period counter width.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous active-high reset.
- sample_valid  input  1  qualifies sample; state frozen when low.
- sample  input  8  offset-binary sample.
- period  output  CNT_W  last measured period, in valid samples.
- peak  output  8  max sample over last measured period.
- trough  output  8  min sample over last measured period.
- amplitude  output  8  peak - trough, updated with peak/trough.
- period_valid  output  1  one-cycle pulse, new result on outputs.
- locked  output  1  high after first period_valid; cleared on timeout or reset.
- timeout  output  1  one-cycle pulse when counter saturates.

Behaviour:
- Reset: state IDLE; period, peak, trough, amplitude = 0; period_valid, locked, timeout = 0; cnt = 0; running max = 0, running min = 255.
- All updates only on cycles with sample_valid=1, except that the period_valid/timeout pulses clear on the next clock regardless of sample_valid.
- FSM states:
  - IDLE: wait for sample <= MID-HYST, then go to LOW_FIRST.
  - LOW_FIRST: wait for sample >= MID+HYST (first rising crossing) -> go to HIGH; cnt <= 1; running max/min <= sample; no result.
  - HIGH: cnt++, max/min update; when sample <= MID-HYST -> go to LOW.
  - LOW: cnt++, max/min update; when sample >= MID+HYST (rising crossing) -> measurement:
    - period <= cnt; peak/trough <= running max/min (excluding the crossing sample); amplitude <= max-min.
    - period_valid pulses and locked <= 1.
    - cnt <= 1; running max/min reinitialised to the crossing sample; go to HIGH.
- Thresholds are inclusive (sample == MID+HYST counts as a rise).
- Samples inside the hysteresis band never change state.
- Latency: outputs and period_valid are registered, visible the cycle after the crossing sample is accepted.
- Period definition: number of valid samples from one crossing sample (inclusive) to the next (exclusive).
  - Minimum reportable period is 2.
  - Generator at phase step 1 gives period = 256; at step 4 gives 64.
- Saturation: if a sample would increment cnt past 2^CNT_W-1 in HIGH or LOW:
  - timeout pulses, locked <= 0, go to IDLE.
  - period/peak/trough/amplitude hold their last values.
  - If this coincides with a crossing, the timeout wins and no period_valid is issued.
- rst mid-measurement discards the partial cycle; the first result after reset needs two rising crossings.

Optional Feature:
- SINE_METER_AVG_EN defined:
  - Rising-crossing measurements accumulate in a CNT_W+2 sum.
  - Every 4th measurement: period <= sum>>2 (truncated), period_valid pulses, sum clears; intermediate measurements produce no pulse.
  - peak/trough/amplitude update only with that 4th measurement, using the last cycle's values.
  - locked sets on the first averaged output.
  - Timeout or reset clears the sum and the group count.
- Undefined: raw per-cycle behaviour as above.

Test Plan:
- Reset, then feed LUT sine with phase step 1, sample_valid=1 continuously -> first period_valid after two rising crossings; period=256, peak=255, trough=0, amplitude=255, locked=1.
- Phase step 4 with sample_valid toggling 1/0 every cycle -> period=64 (invalid cycles not counted), same peak/trough.
- Square-ish input alternating 150/100 every 3 valid samples -> period=6, peak=150, trough=100, amplitude=50; samples of 140/120 inserted -> no state change.
- Constant 200 after lock, CNT_W=8 build -> timeout pulse after 255 samples, locked=0, period holds the previous value; resumed sine relocks after two crossings.
- Assert rst during HIGH mid-cycle -> all outputs 0 next cycle; no period_valid until two new crossings.
- SINE_METER_AVG_EN, periods 64,64,65,66 -> a single period_valid after the 4th, period=64 (259>>2).
